// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings and the MEM-stage FSM state type.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    // Misaligned halfword/word or an encoding that is not a legal RV32I load/store.
    function automatic logic access_illegal(input logic is_load, input logic [2:0] f3,
                                            input logic [1:0] offset);
        logic bad;
        bad = 1'b1;
        if (is_load) begin
            case (f3)
                F3_LB, F3_LBU: bad = 1'b0;
                F3_LH, F3_LHU: bad = offset[0];
                F3_LW:         bad = |offset;
                default:       bad = 1'b1;
            endcase
        end else begin
            case (f3)
                F3_SB:   bad = 1'b0;
                F3_SH:   bad = offset[0];
                F3_SW:   bad = |offset;
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a read word and sign- or zero-extends it.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_lanes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_lanes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = byte_lanes[offset];
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'd0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'd0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: legality check, store lane steering, req/ready bus FSM
// with timeout, and extended load data handed to MEM/WB in the DONE cycle.
module mem_access_stage
    import riscv_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadData,
    output logic        StallM,
    output logic        AccessFaultM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    lsu_state_t  state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg;
    logic [3:0]  be_reg;
    logic [31:0] wdata_reg;
    logic        we_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] rdata_reg;

    logic        access, is_load, illegal, start, busy, timed_out;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] ext_data;

    // A load wins when both strobes are set; reset suppresses any new request.
    assign access  = MemReadM | MemWriteM;
    assign is_load = MemReadM;
    assign illegal = access_illegal(is_load, funct3M, ALUResultM[1:0]);
    assign start   = (state_reg == IDLE) && access && !illegal && !rst;
    assign busy    = (state_reg == BUSY);

    // TIMEOUT==0 disables the watchdog; ready in the last allowed cycle still wins.
    assign timed_out = (TIMEOUT != 8'd0) && (cnt_reg == TIMEOUT - 8'd1) && !dmem_ready;

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = WriteDataM;
        if (!is_load) begin
            case (funct3M)
                F3_SB: begin
                    be_calc    = 4'b0001 << ALUResultM[1:0];
                    wdata_calc = {4{WriteDataM[7:0]}};
                end
                F3_SH: begin
                    be_calc    = 4'b0011 << ALUResultM[1:0];
                    wdata_calc = {2{WriteDataM[15:0]}};
                end
                default: begin
                    be_calc    = 4'b1111;
                    wdata_calc = WriteDataM;
                end
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                    cnt_next   = 8'd0;
                end
            end
            BUSY: begin
                if (dmem_ready || timed_out) begin
                    state_next = DONE;
                end else if (cnt_reg != 8'hFF) begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    load_extend u_load_extend (
        .rdata  (dmem_rdata),
        .offset (addr_reg[1:0]),
        .funct3 (funct3_reg),
        .result (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 8'd0;
            addr_reg   <= 32'd0;
            be_reg     <= 4'd0;
            wdata_reg  <= 32'd0;
            we_reg     <= 1'b0;
            funct3_reg <= 3'd0;
            rdata_reg  <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (start) begin
                addr_reg   <= ALUResultM;
                be_reg     <= be_calc;
                wdata_reg  <= wdata_calc;
                we_reg     <= !is_load;
                funct3_reg <= funct3M;
            end
            if (busy) begin
                if (dmem_ready) begin
                    rdata_reg <= we_reg ? 32'd0 : ext_data;
                end else if (timed_out) begin
                    rdata_reg <= 32'd0;
                end
            end
        end
    end

    assign dmem_req     = busy;
    assign dmem_we      = busy && we_reg;
    assign dmem_addr    = busy ? {addr_reg[31:2], 2'b00} : 32'd0;
    assign dmem_be      = busy ? be_reg : 4'd0;
    assign dmem_wdata   = busy ? wdata_reg : 32'd0;
    assign StallM       = busy || start;
    assign AccessFaultM = ((state_reg == IDLE) && access && illegal && !rst) || (busy && timed_out);
    assign ReadData     = (state_reg == DONE) ? rdata_reg : 32'd0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized load/store traffic against a behavioural model, checked by a queue-driven monitor.
module tb_mem_access_stage;

    localparam int TO = 4;

    logic        clk, rst;
    logic        MemReadM, MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM, WriteDataM;
    logic [31:0] ReadData;
    logic        StallM, AccessFaultM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    mem_access_stage #(.TIMEOUT(8'(TO))) dut (
        .clk(clk), .rst(rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadData(ReadData), .StallM(StallM), .AccessFaultM(AccessFaultM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
    );

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          stalls;
        logic        bus;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          d;
        logic [31:0] rdat;
    } txn_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 0;
    int          rsp_delay = 1;
    logic [31:0] rsp_data = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: legality, lanes and extension from plain arithmetic on the access rules.
    function automatic exp_t model(input txn_t t);
        exp_t        e;
        int          o;
        logic        bad_acc;
        logic [31:0] b, h;
        o = int'(t.addr[1:0]);
        if (t.rd)
            bad_acc = (t.f3 == 3) || (t.f3 >= 6) || ((t.f3 == 1 || t.f3 == 5) && (o % 2 != 0))
                      || (t.f3 == 2 && o != 0);
        else
            bad_acc = (t.f3 > 2) || (t.f3 == 1 && o % 2 != 0) || (t.f3 == 2 && o != 0);
        e.fault = 1'b0; e.rdata = 32'd0; e.stalls = 0; e.bus = 1'b0;
        e.we = 1'b0; e.addr = 32'd0; e.be = 4'd0; e.wdata = 32'd0;
        if (bad_acc) begin
            e.fault = 1'b1;
            return e;
        end
        e.bus  = 1'b1;
        e.we   = !t.rd;
        e.addr = t.addr - 32'(o);
        if (t.rd)            e.be = 4'hF;
        else if (t.f3 == 0)  e.be = 4'(1 << o);
        else if (t.f3 == 1)  e.be = 4'(3 << o);
        else                 e.be = 4'hF;
        if (t.f3 == 0)       e.wdata = (t.wd & 32'hFF) * 32'h0101_0101;
        else if (t.f3 == 1)  e.wdata = (t.wd & 32'hFFFF) * 32'h0001_0001;
        else                 e.wdata = t.wd;
        if (t.d == 0 || t.d > TO) begin
            e.fault  = 1'b1;
            e.stalls = 1 + TO;
        end else begin
            e.stalls = 1 + t.d;
            if (t.rd) begin
                b = (t.rdat >> (8 * o)) & 32'hFF;
                h = (t.rdat >> (16 * (o / 2))) & 32'hFFFF;
                case (t.f3)
                    3'd0:    e.rdata = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
                    3'd4:    e.rdata = b;
                    3'd1:    e.rdata = (h >= 32768) ? (h | 32'hFFFF_0000) : h;
                    3'd5:    e.rdata = h;
                    default: e.rdata = t.rdat;
                endcase
            end
        end
        return e;
    endfunction

    // Bus responder: ready on the d-th BUSY cycle (d==0 never); random noise when idle.
    initial begin
        int busy_cnt;
        busy_cnt = 0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (dmem_req) begin
                busy_cnt++;
                if (rsp_delay != 0 && busy_cnt == rsp_delay) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = rsp_data;
                end else begin
                    dmem_ready = 1'b0;
                    dmem_rdata = $urandom;
                end
            end else begin
                busy_cnt = 0;
                dmem_ready = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
        end
    end

    // Monitor: sample late in each cycle, pop an expectation whenever a transaction retires.
    initial begin
        bit   prev_stall;
        bit   fault_seen;
        int   stall_cnt;
        exp_t e;
        prev_stall = 0; fault_seen = 0; stall_cnt = 0;
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                if (dmem_req) begin
                    if (exp_q.size() == 0 || !exp_q[0].bus) begin
                        chk("unexpected_req", 32'(dmem_req), 32'd0);
                    end else begin
                        chk("bus_addr", dmem_addr, exp_q[0].addr);
                        chk("bus_be", 32'(dmem_be), 32'(exp_q[0].be));
                        chk("bus_we", 32'(dmem_we), 32'(exp_q[0].we));
                        if (exp_q[0].we) chk("bus_wdata", dmem_wdata, exp_q[0].wdata);
                    end
                end
                if (AccessFaultM) fault_seen = 1;
                if (StallM) stall_cnt++;
                if (!StallM && (prev_stall || AccessFaultM)) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_retire", 32'(AccessFaultM), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("read_data", ReadData, e.rdata);
                        chk("fault", 32'(fault_seen), 32'(e.fault));
                        chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                    end
                    fault_seen = 0;
                    stall_cnt = 0;
                end else if (!StallM) begin
                    chk("idle_read_data", ReadData, 32'd0);
                end
                prev_stall = StallM;
            end
        end
    end

    task automatic run_txn(input txn_t t, input int idx);
        bit s, done;
        rsp_delay  = t.d;
        rsp_data   = t.rdat;
        MemReadM   = t.rd;
        MemWriteM  = t.wr;
        funct3M    = t.f3;
        ALUResultM = t.addr;
        WriteDataM = t.wd;
        if (t.rd || t.wr) exp_q.push_back(model(t));
        done = 0;
        for (int k = 0; k < 64; k++) begin
            #3;
            s = StallM;
            @(negedge clk);
            if (!s) begin
                done = 1;
                break;
            end
        end
        if (!done) chk("txn_hang", 32'(StallM), 32'd0);
        $display("txn %0d rd=%b wr=%b f3=%0d addr=%h wd=%h delay=%0d rdata=%h",
                 idx, t.rd, t.wr, t.f3, t.addr, t.wd, t.d, t.rdat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t dir [9];
        txn_t t;
        int   kind;

        rst = 1'b1;
        MemReadM = 0; MemWriteM = 0; funct3M = 0; ALUResultM = 0; WriteDataM = 0;
        #2;
        chk("rst_read_data", ReadData, 32'd0);
        chk("rst_stall", 32'(StallM), 32'd0);
        chk("rst_fault", 32'(AccessFaultM), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_bus", {dmem_we, dmem_be, dmem_addr[26:0]} | dmem_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1;

        dir[0] = '{1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 2, 32'hDEADBEEF};
        dir[1] = '{1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 1, 32'h80FF_0000};
        dir[2] = '{1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 1, 32'h80FF_0000};
        dir[3] = '{1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 1, 32'h8001_1234};
        dir[4] = '{1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 1, 32'h8001_1234};
        dir[5] = '{1'b0, 1'b1, 3'd0, 32'h201, 32'hAB, 1, 32'h0};
        dir[6] = '{1'b0, 1'b1, 3'd2, 32'h202, 32'h1234_5678, 1, 32'h0};
        dir[7] = '{1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 0, 32'h1111_2222};
        dir[8] = '{1'b1, 1'b1, 3'd1, 32'h306, 32'h0, 4, 32'h7FFF_0000};
        for (int i = 0; i < 9; i++) run_txn(dir[i], i);

        for (int i = 0; i < 160; i++) begin
            kind   = int'($urandom_range(0, 3));
            t.rd   = (kind == 1) || (kind == 3);
            t.wr   = (kind >= 2);
            t.f3   = 3'($urandom_range(0, 7));
            t.addr = ($urandom & 32'h0000_FFFC) | (($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : 32'd0);
            t.wd   = $urandom;
            t.d    = int'($urandom_range(0, 5));
            t.rdat = $urandom;
            run_txn(t, 9 + i);
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset while a load is outstanding: request drops at once, nothing faults.
        mon_en = 0;
        rsp_delay = 0;
        MemReadM = 1; MemWriteM = 0; funct3M = 3'd2; ALUResultM = 32'h300;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_busy_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_req", 32'(dmem_req), 32'd0);
        chk("rst_mid_stall", 32'(StallM), 32'd0);
        chk("rst_mid_fault", 32'(AccessFaultM), 32'd0);
        MemReadM = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #3;
            chk("post_rst_idle", {30'd0, StallM, dmem_req} | ReadData, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
